// File: rtl/alu_exec_display.sv
// Single-stage ALU with valid/ready handshake and registered result,
// plus a multiplexed 4-digit hex seven-segment readout of rd.
module alu_exec_display #(
    parameter int WIDTH        = 8,
    parameter int REFRESH_BITS = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    input  logic [2:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] rd,
    output logic [1:0]       flags,
    output logic [6:0]       seg,
    output logic [3:0]       an
);

    localparam int DIGITS = WIDTH / 4;

    logic                    out_valid_q, out_valid_d;
    logic [WIDTH-1:0]        rd_q, rd_d;
    logic [1:0]              flags_q, flags_d;
    logic [REFRESH_BITS-1:0] cnt_q, cnt_d;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] alu_res;
    logic [1:0]       alu_flags;
    logic             accept;

    assign in_ready  = ~out_valid_q | out_ready;
    assign accept    = in_valid & in_ready;
    assign out_valid = out_valid_q;
    assign rd        = rd_q;
    assign flags     = flags_q;

    always_comb begin
        sum       = {1'b0, rs} + {1'b0, rt};
        diff      = {1'b0, rs} - {1'b0, rt};
        alu_res   = '0;
        alu_flags = 2'b00;
        case (sel)
            3'd0: begin
                alu_res   = diff[WIDTH-1:0];
                // carry on subtract means "no borrow"
                alu_flags = {(rs[WIDTH-1] ^ rt[WIDTH-1]) &
                             (diff[WIDTH-1] ^ rs[WIDTH-1]),
                             ~diff[WIDTH]};
            end
            3'd1: begin
                alu_res   = sum[WIDTH-1:0];
                alu_flags = {~(rs[WIDTH-1] ^ rt[WIDTH-1]) &
                             (sum[WIDTH-1] ^ rs[WIDTH-1]),
                             sum[WIDTH]};
            end
            3'd2: alu_res = rs | rt;
            3'd3: alu_res = rs & rt;
            3'd4: alu_res = {rt[WIDTH-1], rt[WIDTH-1:1]};
            3'd5: alu_res = {rs[WIDTH-2:0], rs[WIDTH-1]};
            3'd6: alu_res = {{(WIDTH-1){1'b0}}, rs < rt};
            default: alu_res = {{(WIDTH-1){1'b0}}, rs == rt};
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        rd_d        = rd_q;
        flags_d     = flags_q;
        cnt_d       = cnt_q + 1'b1;
        if (accept) begin
            out_valid_d = 1'b1;
            rd_d        = alu_res;
            flags_d     = alu_flags;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            rd_q        <= '0;
            flags_q     <= 2'b00;
            cnt_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            rd_q        <= rd_d;
            flags_q     <= flags_d;
            cnt_q       <= cnt_d;
        end
    end

    logic [1:0]  digit;
    logic [15:0] rd_ext;
    logic [3:0]  nib;
    logic [6:0]  glyph;

    assign digit  = cnt_q[REFRESH_BITS-1 -: 2];
    assign rd_ext = 16'(rd_q);
    assign nib    = rd_ext[{digit, 2'b00} +: 4];

    // active-low, bit order {g,f,e,d,c,b,a}
    always_comb begin
        case (nib)
            4'h0: glyph = 7'b1000000;
            4'h1: glyph = 7'b1111001;
            4'h2: glyph = 7'b0100100;
            4'h3: glyph = 7'b0110000;
            4'h4: glyph = 7'b0011001;
            4'h5: glyph = 7'b0010010;
            4'h6: glyph = 7'b0000010;
            4'h7: glyph = 7'b1111000;
            4'h8: glyph = 7'b0000000;
            4'h9: glyph = 7'b0010000;
            4'hA: glyph = 7'b0001000;
            4'hB: glyph = 7'b0000011;
            4'hC: glyph = 7'b1000110;
            4'hD: glyph = 7'b0100001;
            4'hE: glyph = 7'b0000110;
            default: glyph = 7'b0001110;
        endcase
    end

    always_comb begin
        if (int'(digit) >= DIGITS) begin
            an  = 4'b1111;
            seg = 7'b1111111;
        end else begin
            an  = ~(4'b0001 << digit);
            seg = glyph;
        end
    end

endmodule

// File: tb/tb_alu_exec_display.sv
// Randomized and directed checks of alu_exec_display against a
// behavioural model (WIDTH=8, REFRESH_BITS=4).
module tb_alu_exec_display;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] rs = '0;
    logic [7:0] rt = '0;
    logic [2:0] sel = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] rd;
    logic [1:0] flags;
    logic [6:0] seg;
    logic [3:0] an;

    int n_cmp = 0;
    int n_bad = 0;
    bit live_chk = 1'b0;

    alu_exec_display #(.WIDTH(8), .REFRESH_BITS(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .rs(rs), .rt(rt), .sel(sel),
        .out_valid(out_valid), .out_ready(out_ready),
        .rd(rd), .flags(flags), .seg(seg), .an(an)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model
    logic [6:0] glyph_tab [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    bit m_valid;
    int m_rd, m_flags, m_cnt;

    function automatic int ref_alu(input int op, input int a, input int b);
        int r, c, o, sa, sb, s;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        c = 0;
        o = 0;
        case (op)
            0: begin
                r = (a - b + 256) % 256;
                c = (a >= b) ? 1 : 0;
                s = sa - sb;
                o = (s < -128 || s > 127) ? 1 : 0;
            end
            1: begin
                r = (a + b) % 256;
                c = (a + b > 255) ? 1 : 0;
                s = sa + sb;
                o = (s < -128 || s > 127) ? 1 : 0;
            end
            2: r = a | b;
            3: r = a & b;
            4: r = (b / 2) + ((b >= 128) ? 128 : 0);
            5: r = ((a * 2) % 256) + a / 128;
            6: r = (a < b) ? 1 : 0;
            default: r = (a == b) ? 1 : 0;
        endcase
        return (o * 2 + c) * 256 + r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid = 1'b0;
            m_rd    = 0;
            m_flags = 0;
            m_cnt   = 0;
        end else begin
            int res;
            m_cnt = (m_cnt + 1) % 16;
            if (in_valid && (!m_valid || out_ready)) begin
                res     = ref_alu(int'(sel), int'(rs), int'(rt));
                m_rd    = res % 256;
                m_flags = res / 256;
                m_valid = 1'b1;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (live_chk && !rst) begin
            int d;
            int exp_an, exp_seg;
            d = m_cnt / 4;
            if (d < 2) begin
                exp_an  = 15 - (1 << d);
                exp_seg = int'(glyph_tab[(m_rd >> (4 * d)) % 16]);
            end else begin
                exp_an  = 15;
                exp_seg = 127;
            end
            chk("m_out_valid", int'(out_valid), int'(m_valid));
            chk("m_in_ready", int'(in_ready), int'(!m_valid || out_ready));
            chk("m_rd", int'(rd), m_rd);
            chk("m_flags", int'(flags), m_flags);
            chk("m_an", int'(an), exp_an);
            chk("m_seg", int'(seg), exp_seg);
        end
    end

    task automatic op(input int s, input int a, input int b,
                      input int exp_rd, input int exp_fl, input string nm);
        @(negedge clk);
        #1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        sel = 3'(s);
        rs  = 8'(a);
        rt  = 8'(b);
        @(negedge clk);
        chk({nm, "_rd"}, int'(rd), exp_rd);
        chk({nm, "_flags"}, int'(flags), exp_fl);
        chk({nm, "_valid"}, int'(out_valid), 1);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        #3;
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_rd", int'(rd), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_an", int'(an), 4'b1110);
        chk("rst_seg", int'(seg), 7'b1000000);
        @(negedge clk);
        rst = 1'b0;
        live_chk = 1'b1;

        op(1, 8'h7F, 8'h01, 8'h80, 2'b10, "add_ovf");
        op(0, 8'h03, 8'h05, 8'hFE, 2'b00, "sub_borrow");
        op(5, 8'h81, 8'h00, 8'h03, 2'b00, "rol");
        op(4, 8'h00, 8'h81, 8'hC0, 2'b00, "sra");
        op(6, 8'h03, 8'h05, 8'h01, 2'b00, "sltu");
        op(7, 8'h22, 8'h22, 8'h01, 2'b00, "eq");
        op(0, 8'h05, 8'h03, 8'h02, 2'b01, "sub_nb");

        // backpressure
        op(2, 8'h50, 8'h0A, 8'h5A, 2'b00, "or");
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        sel = 3'd1;
        rs  = 8'h01;
        rt  = 8'h01;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready", int'(in_ready), 0);
            chk("bp_rd_hold", int'(rd), 8'h5A);
            chk("bp_valid", int'(out_valid), 1);
            #1;
            rs = 8'(i + 7);
            rt = 8'(i + 9);
        end
        rs = 8'h01;
        rt = 8'h01;
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", int'(in_ready), 1);
        @(negedge clk);
        chk("bp_new_rd", int'(rd), 8'h02);
        chk("bp_valid_kept", int'(out_valid), 1);
        #1;
        in_valid = 1'b0;

        // reset with pending 5A
        op(2, 8'h50, 8'h0A, 8'h5A, 2'b00, "or2");
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_rd", int'(rd), 0);
        chk("arst_valid", int'(out_valid), 0);
        chk("arst_an", int'(an), 4'b1110);
        chk("arst_seg", int'(seg), 7'b1000000);
        chk("arst_in_ready", int'(in_ready), 1);
        @(negedge clk);
        rst = 1'b0;

        // display scan with rd = A5
        op(2, 8'hA0, 8'h05, 8'hA5, 2'b00, "disp_load");
        #1;
        out_ready = 1'b0;
        begin
            int guard;
            guard = 0;
            while (m_cnt != 0 && guard < 32) begin
                @(negedge clk);
                guard++;
            end
            chk("disp_sync_timeout", int'(m_cnt != 0), 0);
        end
        for (int i = 0; i < 32; i++) begin
            int ph;
            ph = i % 16;
            if (ph < 4) begin
                chk("disp_an0", int'(an), 4'b1110);
                chk("disp_seg5", int'(seg), 7'b0010010);
            end else if (ph < 8) begin
                chk("disp_an1", int'(an), 4'b1101);
                chk("disp_segA", int'(seg), 7'b0001000);
            end else begin
                chk("disp_an_blank", int'(an), 4'b1111);
                chk("disp_seg_blank", int'(seg), 7'b1111111);
            end
            @(negedge clk);
        end

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            #1;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            sel = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: rs = 8'h80;
                1: rs = 8'h7F;
                default: rs = 8'($urandom);
            endcase
            rt = ($urandom_range(0, 4) == 0) ? rs : 8'($urandom);
            if (i == 300) begin
                #1;
                rst = 1'b1;
                #1;
                chk("rand_arst_valid", int'(out_valid), 0);
                rst = 1'b0;
            end
            @(negedge clk);
        end

        live_chk = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_exec_display.md
ALU_EXEC_DISPLAY -- requirements
Module: alu_exec_display

Interface
REQ-001 The block SHALL take parameter WIDTH, default 8, meaning operand/result width; legal values 4, 8, 12, 16.
REQ-002 The block SHALL take parameter REFRESH_BITS, default 17, meaning the width of the display scan counter; minimum 3.
REQ-003 Port clk SHALL be input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 Port rst SHALL be input, 1 bit, asynchronous active-high reset.
REQ-005 Port in_valid SHALL be input, 1 bit, meaning an operation is offered.
REQ-006 Port in_ready SHALL be output, 1 bit, meaning the block accepts an operation this cycle.
REQ-007 Port rs SHALL be input, WIDTH bits, first operand.
REQ-008 Port rt SHALL be input, WIDTH bits, second operand.
REQ-009 Port sel SHALL be input, 3 bits, opcode.
REQ-010 Port out_valid SHALL be output, 1 bit, meaning rd/flags hold an unconsumed result.
REQ-011 Port out_ready SHALL be input, 1 bit, meaning the consumer takes the result.
REQ-012 Port rd SHALL be output, WIDTH bits, registered result.
REQ-013 Port flags SHALL be output, 2 bits, registered {overflow, carry}.
REQ-014 Port seg SHALL be output, 7 bits, active-low segments, seg[0]=a through seg[6]=g.
REQ-015 Port an SHALL be output, 4 bits, active-low digit enables, an[0]=rightmost digit.

Function
REQ-016 An operation SHALL be accepted on a rising edge where in_valid and in_ready are both 1.
REQ-017 in_ready SHALL equal (not out_valid) or out_ready, combinationally.
REQ-018 An accepted operation SHALL load rd, flags and out_valid=1 on the same edge (latency 1 cycle).
REQ-019 When out_valid=1 and out_ready=1 with no new acceptance, out_valid SHALL clear on that edge; rd and flags SHALL keep their values.
REQ-020 Simultaneous consume and accept SHALL keep out_valid=1 and load the new result.
REQ-021 While out_valid=1 and out_ready=0, rd, flags and out_valid SHALL hold; rs/rt/sel changes SHALL be ignored.
REQ-022 sel=0 SHALL give rd=rs-rt mod 2^WIDTH, carry=1 if no borrow (rs>=rt unsigned), overflow=signed overflow.
REQ-023 sel=1 SHALL give rd=rs+rt mod 2^WIDTH, carry=unsigned carry-out, overflow=signed overflow.
REQ-024 sel=2 SHALL give rd=rs OR rt; sel=3 SHALL give rd=rs AND rt.
REQ-025 sel=4 SHALL give rd=rt arithmetic-shifted right by 1 (MSB replicated).
REQ-026 sel=5 SHALL give rd=rs rotated left by 1 (old MSB into bit 0).
REQ-027 sel=6 SHALL give rd=1 if rs<rt unsigned else 0, upper WIDTH-1 bits zero.
REQ-028 sel=7 SHALL give rd=1 if rs==rt else 0, upper WIDTH-1 bits zero.
REQ-029 For sel 2..7, flags SHALL be loaded as 2'b00.
REQ-030 A free-running REFRESH_BITS-wide scan counter SHALL increment every cycle and wrap to 0.
REQ-031 The counter's top two bits SHALL select digit d (0..3); an SHALL have only bit d low.
REQ-032 Digit d SHALL display hex nibble rd[4d+3:4d] using standard 0-F glyphs (b and d lowercase).
REQ-033 Digits with d >= WIDTH/4 SHALL be blanked: an=4'b1111, seg=7'b1111111.
REQ-034 The display SHALL show rd regardless of out_valid.

Reset
REQ-035 While rst=1, out_valid=0, rd=0, flags=0, scan counter=0, independent of clk.
REQ-036 During reset in_ready SHALL read 1, an=4'b1110, seg=7'b1000000 (glyph 0).
REQ-037 Reset asserted mid-transaction SHALL discard any pending result; no operation is accepted while rst=1.

Verification
REQ-038 Reset: assert rst with out_valid=1 and rd=8'h5A -> rd=0, out_valid=0, an=1110, seg=1000000 immediately without a clock edge.
REQ-039 Add/sub: WIDTH=8, sel=1, rs=8'h7F, rt=8'h01 -> next cycle rd=8'h80, flags=2'b10; sel=0, rs=8'h03, rt=8'h05 -> rd=8'hFE, flags=2'b00.
REQ-040 Shift/compare: sel=5, rs=8'h81 -> rd=8'h03; sel=4, rt=8'h81 -> rd=8'hC0; sel=6, rs=3, rt=5 -> rd=8'h01; sel=7, rs=rt=8'h22 -> rd=8'h01.
REQ-041 Backpressure: result pending, out_ready=0, in_valid=1 for 3 cycles -> in_ready=0 and rd unchanged; then out_ready=1 -> in_ready=1 and the new result loads on that edge with out_valid staying 1.
REQ-042 Display: WIDTH=8, REFRESH_BITS=4, rd=8'hA5 -> an=1110 with seg=0010010 for 4 cycles, then an=1101 with seg=0001000 for 4 cycles, then an=1111 with seg=1111111 for 8 cycles, repeating.
